// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory bus port between instruction fetch and
//            load/store. Data has priority, and a streak limit stops fetch
//            from starving. Hung bus cycles are ended by a timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read_in,
    input  logic [63:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [63:0] instr_read_value_out,
    output logic        instr_fault_out,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [63:0] data_address_in,
    input  logic [63:0] data_write_value_in,
    input  logic [7:0]  data_write_mask_in,
    output logic        data_ready_out,
    output logic [63:0] data_read_value_out,
    output logic        data_fault_out,
    output logic [63:0] bus_address_out,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [63:0] bus_write_value_out,
    output logic [7:0]  bus_write_mask_out,
    input  logic [63:0] bus_read_value_in,
    input  logic        bus_ready_in
);

    localparam int c_streak_w = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam int c_timer_w  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DATA_STREAK);
    localparam logic [c_timer_w-1:0]  c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_GNT_INSTR = 2'd1;
    localparam logic [1:0] c_GNT_DATA  = 2'd2;

    logic [1:0]            r_state;
    logic [c_streak_w-1:0] r_streak;
    logic [c_timer_w-1:0]  r_timer;
    logic [63:0]           r_addr;
    logic                  r_read;
    logic                  r_write;
    logic [63:0]           r_wdata;
    logic [7:0]            r_mask;

    logic w_data_req;
    logic w_grant_data;
    logic w_busy;
    logic w_timeout;
    logic w_done;

    assign w_data_req   = data_read_in | data_write_in;
    assign w_grant_data = w_data_req && (!instr_read_in || (r_streak < c_streak_max));
    assign w_busy       = (r_state != c_IDLE);
    assign w_timeout    = w_busy && !bus_ready_in && (r_timer == c_timer_last);
    assign w_done       = w_busy && (bus_ready_in || w_timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_streak <= '0;
            r_timer  <= '0;
            r_addr   <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_mask   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_timer <= '0;
                    if (w_grant_data) begin
                        r_state <= c_GNT_DATA;
                        r_addr  <= data_address_in;
                        // A simultaneous read+write strobe is resolved as a write.
                        r_write <= data_write_in;
                        r_read  <= data_read_in & ~data_write_in;
                        r_wdata <= data_write_value_in;
                        r_mask  <= data_write_mask_in;
                        if (!instr_read_in) begin
                            r_streak <= '0;
                        end else if (r_streak < c_streak_max) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end else if (instr_read_in) begin
                        r_state  <= c_GNT_INSTR;
                        r_addr   <= instr_address_in;
                        r_read   <= 1'b1;
                        r_write  <= 1'b0;
                        r_wdata  <= '0;
                        r_mask   <= '0;
                        r_streak <= '0;
                    end
                end
                c_GNT_INSTR, c_GNT_DATA: begin
                    if (w_done) begin
                        r_state <= c_IDLE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus_address_out     = w_busy ? r_addr  : '0;
    assign bus_read_out        = w_busy & r_read;
    assign bus_write_out       = w_busy & r_write;
    assign bus_write_value_out = w_busy ? r_wdata : '0;
    assign bus_write_mask_out  = w_busy ? r_mask  : '0;

    // A timed-out completion returns zero data regardless of the bus lines.
    assign instr_ready_out      = (r_state == c_GNT_INSTR) && w_done;
    assign instr_fault_out      = (r_state == c_GNT_INSTR) && w_timeout;
    assign instr_read_value_out = ((r_state == c_GNT_INSTR) && bus_ready_in) ? bus_read_value_in : '0;
    assign data_ready_out       = (r_state == c_GNT_DATA) && w_done;
    assign data_fault_out       = (r_state == c_GNT_DATA) && w_timeout;
    assign data_read_value_out  = ((r_state == c_GNT_DATA) && bus_ready_in) ? bus_read_value_in : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter with requester agents and a
//            bus responder of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int MAX_DATA_STREAK = 4;
    localparam int TIMEOUT_CYCLES  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read_in;
    logic [63:0] instr_address_in;
    logic        instr_ready_out;
    logic [63:0] instr_read_value_out;
    logic        instr_fault_out;
    logic        data_read_in;
    logic        data_write_in;
    logic [63:0] data_address_in;
    logic [63:0] data_write_value_in;
    logic [7:0]  data_write_mask_in;
    logic        data_ready_out;
    logic [63:0] data_read_value_out;
    logic        data_fault_out;
    logic [63:0] bus_address_out;
    logic        bus_read_out;
    logic        bus_write_out;
    logic [63:0] bus_write_value_out;
    logic [7:0]  bus_write_mask_out;
    logic [63:0] bus_read_value_in;
    logic        bus_ready_in;

    mem_arbiter #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_ready_out      (instr_ready_out),
        .instr_read_value_out (instr_read_value_out),
        .instr_fault_out      (instr_fault_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_address_in      (data_address_in),
        .data_write_value_in  (data_write_value_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_ready_out       (data_ready_out),
        .data_read_value_out  (data_read_value_out),
        .data_fault_out       (data_fault_out),
        .bus_address_out      (bus_address_out),
        .bus_read_out         (bus_read_out),
        .bus_write_out        (bus_write_out),
        .bus_write_value_out  (bus_write_value_out),
        .bus_write_mask_out   (bus_write_mask_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } data_cmd_t;

    typedef struct {
        bit          is_data;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        int          start;
    } grant_t;

    typedef struct {
        logic [63:0] value;
        bit          fault;
        int          cycles;
    } resp_t;

    logic [63:0] instr_cmd_q[$];
    data_cmd_t   data_cmd_q[$];
    grant_t      grant_q[$];
    resp_t       instr_exp_q[$];
    resp_t       data_exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bus_latency = 1;
    bit force_ready   = 1'b0;
    bit abort_req     = 1'b0;
    bit scramble_addr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return 64'hDEADBEEF_00000013 + (a - 64'h1000);
    endfunction

    // Bus responder: ready after bus_latency wait cycles (-1 = never).
    initial begin : bus_model
        int wait_cnt;
        wait_cnt          = 0;
        bus_ready_in      = 1'b0;
        bus_read_value_in = 64'h5A5A_5A5A_5A5A_5A5A;
        forever begin
            @(posedge clk);
            #2;
            if (bus_read_out || bus_write_out) begin
                if (bus_latency >= 0 && wait_cnt == bus_latency) begin
                    bus_ready_in      = 1'b1;
                    bus_read_value_in = bus_read_out ? mem_val(bus_address_out) : 64'h0;
                    wait_cnt          = 0;
                end else begin
                    bus_ready_in      = 1'b0;
                    bus_read_value_in = 64'h5A5A_5A5A_5A5A_5A5A;
                    wait_cnt++;
                end
            end else begin
                wait_cnt          = 0;
                bus_ready_in      = force_ready;
                bus_read_value_in = 64'h5A5A_5A5A_5A5A_5A5A;
            end
        end
    end

    initial begin : instr_agent
        bit got;
        int stall;
        instr_read_in    = 1'b0;
        instr_address_in = '0;
        stall            = 0;
        forever begin
            @(negedge clk);
            got = instr_ready_out;
            @(posedge clk);
            #1;
            if (abort_req) begin
                instr_read_in = 1'b0;
                instr_cmd_q.delete();
                stall = 0;
            end else if (instr_read_in && !got) begin
                stall++;
                if (stall > 300) begin
                    check_eq("instr_stall", stall, 0);
                    instr_read_in = 1'b0;
                    stall = 0;
                end
            end else begin
                stall = 0;
                if (instr_cmd_q.size() > 0) begin
                    instr_address_in = instr_cmd_q.pop_front();
                    instr_read_in    = 1'b1;
                end else begin
                    instr_read_in = 1'b0;
                end
            end
        end
    end

    initial begin : data_agent
        data_cmd_t c;
        bit got;
        int stall;
        data_read_in        = 1'b0;
        data_write_in       = 1'b0;
        data_address_in     = '0;
        data_write_value_in = '0;
        data_write_mask_in  = '0;
        stall               = 0;
        forever begin
            @(negedge clk);
            got = data_ready_out;
            @(posedge clk);
            #1;
            if (abort_req) begin
                data_read_in  = 1'b0;
                data_write_in = 1'b0;
                data_cmd_q.delete();
                stall = 0;
            end else if ((data_read_in || data_write_in) && !got) begin
                stall++;
                // Perturb the address after grant; the bus must keep the latched copy.
                if (scramble_addr) data_address_in = ~data_address_in;
                if (stall > 300) begin
                    check_eq("data_stall", stall, 0);
                    data_read_in  = 1'b0;
                    data_write_in = 1'b0;
                    stall = 0;
                end
            end else begin
                stall = 0;
                if (data_cmd_q.size() > 0) begin
                    c = data_cmd_q.pop_front();
                    data_read_in        = c.rd;
                    data_write_in       = c.wr;
                    data_address_in     = c.addr;
                    data_write_value_in = c.wdata;
                    data_write_mask_in  = c.mask;
                end else begin
                    data_read_in  = 1'b0;
                    data_write_in = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        grant_t cur;
        resp_t  e;
        bit     in_txn;
        bit     prev_ready;
        int     strobe_cycles;
        in_txn        = 1'b0;
        prev_ready    = 1'b0;
        strobe_cycles = 0;
        cur           = '{default: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                in_txn        = 1'b0;
                prev_ready    = 1'b0;
                strobe_cycles = 0;
            end else begin
                if (prev_ready) check_eq("bubble_idle", {bus_read_out, bus_write_out}, 2'b00);
                if ((bus_read_out || bus_write_out) && !in_txn) begin
                    in_txn        = 1'b1;
                    strobe_cycles = 0;
                    if (grant_q.size() == 0) begin
                        check_eq("grant_unexpected", grant_q.size(), 1);
                    end else begin
                        cur = grant_q.pop_front();
                        check_eq("grant_addr", bus_address_out, cur.addr);
                        check_eq("grant_strobes", {bus_write_out, bus_read_out}, {cur.wr, !cur.wr});
                        if (cur.wr) begin
                            check_eq("grant_wdata", bus_write_value_out, cur.wdata);
                            check_eq("grant_mask", bus_write_mask_out, cur.mask);
                        end
                        if (cur.start >= 0) check_eq("grant_cycle", cyc, cur.start);
                    end
                end else if (bus_read_out || bus_write_out) begin
                    check_eq("addr_hold", bus_address_out, cur.addr);
                end
                if (bus_read_out || bus_write_out) strobe_cycles++;
                if (!instr_ready_out) check_eq("instr_val_idle", instr_read_value_out, 0);
                if (!data_ready_out)  check_eq("data_val_idle", data_read_value_out, 0);
                if (instr_ready_out) begin
                    check_eq("instr_owner", cur.is_data, 0);
                    if (instr_exp_q.size() == 0) begin
                        check_eq("instr_unexpected_ready", instr_exp_q.size(), 1);
                    end else begin
                        e = instr_exp_q.pop_front();
                        check_eq("instr_value", instr_read_value_out, e.value);
                        check_eq("instr_fault", instr_fault_out, e.fault);
                        check_eq("instr_latency", strobe_cycles, e.cycles);
                    end
                    in_txn = 1'b0;
                end
                if (data_ready_out) begin
                    check_eq("data_owner", cur.is_data, 1);
                    if (data_exp_q.size() == 0) begin
                        check_eq("data_unexpected_ready", data_exp_q.size(), 1);
                    end else begin
                        e = data_exp_q.pop_front();
                        check_eq("data_value", data_read_value_out, e.value);
                        check_eq("data_fault", data_fault_out, e.fault);
                        check_eq("data_latency", strobe_cycles, e.cycles);
                    end
                    in_txn = 1'b0;
                end
                prev_ready = instr_ready_out | data_ready_out;
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((instr_cmd_q.size() + data_cmd_q.size() + instr_exp_q.size()
                + data_exp_q.size() + grant_q.size()) != 0
               || instr_read_in || data_read_in || data_write_in) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                check_eq(tag, n, 0);
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_grant(input bit is_data, input bit wr, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] mask, input int start);
        grant_t g;
        g.is_data = is_data;
        g.wr      = wr;
        g.addr    = addr;
        g.wdata   = wdata;
        g.mask    = mask;
        g.start   = start;
        grant_q.push_back(g);
    endtask

    task automatic push_data(input bit rd, input bit wr, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] mask);
        data_cmd_t c;
        c.rd    = rd;
        c.wr    = wr;
        c.addr  = addr;
        c.wdata = wdata;
        c.mask  = mask;
        data_cmd_q.push_back(c);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_bus_addr", bus_address_out | bus_write_value_out, 0);
        check_eq("rst_bus_ctl", {bus_read_out, bus_write_out, bus_write_mask_out}, 0);
        check_eq("rst_ready", {instr_ready_out, instr_fault_out, data_ready_out, data_fault_out}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch alone, one wait state.
        bus_latency = 1;
        push_grant(0, 0, 64'h1000, 0, 0, cyc + 2);
        instr_exp_q.push_back('{mem_val(64'h1000), 1'b0, 2});
        instr_cmd_q.push_back(64'h1000);
        drain("drain_fetch");

        // Store and fetch together: store first, fetch in the next IDLE.
        bus_latency = 0;
        push_grant(1, 1, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF, cyc + 2);
        push_grant(0, 0, 64'h1008, 0, 0, cyc + 4);
        data_exp_q.push_back('{64'h0, 1'b0, 1});
        instr_exp_q.push_back('{mem_val(64'h1008), 1'b0, 1});
        push_data(0, 1, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF);
        instr_cmd_q.push_back(64'h1008);
        drain("drain_both");

        // Continuous loads with fetch held: D,D,D,D,I,D,D.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) push_grant(0, 0, 64'h1010, 0, 0, -1);
            push_grant(1, 0, 64'h3000 + 64'(8 * i), 0, 8'h0F, -1);
            push_data(1, 0, 64'h3000 + 64'(8 * i), 0, 8'h0F);
            data_exp_q.push_back('{mem_val(64'h3000 + 64'(8 * i)), 1'b0, 1});
        end
        instr_cmd_q.push_back(64'h1010);
        instr_exp_q.push_back('{mem_val(64'h1010), 1'b0, 1});
        drain("drain_streak");

        // Bus never answers: fault on the last timeout cycle.
        bus_latency = -1;
        push_grant(1, 0, 64'h5000, 0, 8'hFF, -1);
        push_data(1, 0, 64'h5000, 0, 8'hFF);
        data_exp_q.push_back('{64'h0, 1'b1, TIMEOUT_CYCLES});
        drain("drain_timeout");

        // Reset while a store is outstanding.
        push_grant(1, 1, 64'h6000, 64'hABCD, 8'h01, -1);
        push_data(0, 1, 64'h6000, 64'hABCD, 8'h01);
        n = 0;
        while (!bus_write_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_txn_started", bus_write_out, 1);
        @(negedge clk);
        abort_req = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_bus", {bus_read_out, bus_write_out, bus_address_out}, 0);
        check_eq("midrst_ready", {instr_ready_out, data_ready_out, data_fault_out}, 0);
        force_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("ready_after_reset", {instr_ready_out, data_ready_out, bus_write_out}, 0);
        end
        force_ready = 1'b0;
        abort_req   = 1'b0;
        repeat (2) @(negedge clk);

        // Read+write together acts as a write; address changes after grant are ignored.
        bus_latency   = 3;
        scramble_addr = 1'b1;
        push_grant(1, 1, 64'h7000, 64'hCAFE_F00D_0000_0001, 8'h3C, cyc + 2);
        push_data(1, 1, 64'h7000, 64'hCAFE_F00D_0000_0001, 8'h3C);
        data_exp_q.push_back('{64'h0, 1'b0, 4});
        drain("drain_latch");
        scramble_addr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
